fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: holds the program counter, the instruction memory and the IF/ID pipeline register. It feeds the decode stage with the fetched instruction and its PC+1, and consumes decode's redirect, stall and halt controls. It also accepts a byte stream from the debug unit to load the program into instruction memory.

## Interface
- NB_DATA, 32, instruction/word width
- NB_ADDR, 7, word-address width; memory depth = 2^NB_ADDR words
- NB_BYTE, 8, load-stream byte width
- i_clock  in  1  stage clock, all state on rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_enable  in  1  run/step enable from debug unit; 0 freezes PC and IF/ID
- i_pc_write  in  1  PC update enable from hazard unit (0 = stall)
- i_IF_ID_write  in  1  IF/ID update enable from hazard unit (0 = stall)
- i_branch_or_jump  in  1  redirect taken, resolved in decode
- i_pc_src  in  2  redirect target select: 00 PC+1, 01 branch, 10 jump, 11 register
- i_addr_branch  in  NB_ADDR  branch target
- i_addr_jump  in  NB_ADDR  jump target
- i_addr_register  in  NB_ADDR  jr/jalr target
- i_halt  in  1  halt detected in decode
- i_load_en  in  1  program-load mode
- i_load_valid  in  1  load byte strobe
- i_load_byte  in  NB_BYTE  load byte, first byte of a word is bits [31:24]
- o_instruction  out  NB_DATA  IF/ID instruction
- o_pc  out  NB_ADDR  IF/ID PC+1 of that instruction
- o_pc_current  out  NB_ADDR  current PC (debug readout)
- o_halted  out  1  fetch frozen by halt
- o_load_words  out  NB_ADDR+1  words written since load mode entered
- o_mem_full  out  1  last memory word written during current load

## Operation
- Reset (i_reset=0, asynchronous): PC=0, IF/ID instruction=0 (NOP), o_pc=0, o_halted=0, byte counter=0, load address=0, o_load_words=0, o_mem_full=0. Memory contents are not reset.
- Read: instruction = mem[PC], combinational from the array. PC+1 wraps modulo 2^NB_ADDR.
- Priority per cycle, highest first: load mode, halted, !i_enable, stall, redirect, sequential.
- Load mode (i_load_en=1): PC forced to 0, IF/ID forced to NOP, o_halted cleared. On each i_load_valid the byte is shifted into the word assembler; byte counter 0→3. On the 4th byte the word is written to mem[load_addr], load_addr++, o_load_words++. At load_addr = 2^NB_ADDR−1 the write sets o_mem_full. Further bytes are ignored while o_mem_full=1.
- Leaving load mode (i_load_en=0): byte counter and load_addr clear. A partial word is discarded. o_load_words and o_mem_full hold until the next rising of i_load_en, where they clear.
- Halt: i_halt=1 with i_enable=1 and not load mode sets o_halted. While halted, PC and IF/ID hold. Only reset or load mode clears it. The halt instruction itself stays in IF/ID.
- i_enable=0: PC and IF/ID hold.
- Stall: i_pc_write=0 holds PC and ignores i_branch_or_jump. i_IF_ID_write=0 holds IF/ID.
- Redirect: i_branch_or_jump=1 with i_pc_write=1 sets PC to the target selected by i_pc_src. If i_pc_src=00, PC+1 is used. If i_IF_ID_write=1, IF/ID is loaded with NOP (flush, no delay slot) and o_pc is written as target.
- Sequential: PC←PC+1, IF/ID←{mem[PC], PC+1}.

## Timing
- Fetch latency: instruction at PC appears on o_instruction one cycle after PC holds it.
- Redirect penalty: one bubble. The target instruction reaches IF/ID 2 edges after the redirect is asserted.
- Load: a word is visible in memory (readable at PC) on the edge after its 4th byte. Throughput is 1 byte per cycle.
- All outputs are registered except o_pc_current, which is a direct PC register view.
- Asynchronous reset mid-load or mid-run: everything returns to reset values immediately. Memory retains words already written.

## Test plan
- Load 0x20010005, 0x20020003 byte-wise (8 strobes, bytes 20 01 00 05 20 02 00 03) → mem[0]=0x20010005, mem[1]=0x20020003, o_load_words=2. Then i_load_en=0 with i_enable=1 → o_instruction=0x20010005/o_pc=1 after the 1st edge, 0x20020003/o_pc=2 after the 2nd.
- Running at PC=4: assert i_branch_or_jump=1, i_pc_src=01, i_addr_branch=0x10 → next edge PC=0x10 and IF/ID=NOP. The following edge IF/ID=mem[0x10] with o_pc=0x11. Repeat with src 10 (jump 0x20) and 11 (register 0x30).
- Stall: i_pc_write=0 and i_IF_ID_write=0 for 2 cycles while i_branch_or_jump=1 → PC and o_instruction unchanged, no redirect. Release → normal fetch resumes from the held PC.
- Halt at PC=6: assert i_halt 1 cycle → o_halted=1, PC stays 6 indefinitely. i_load_en pulse → o_halted=0, PC=0.
- Fill memory: 4·128 bytes → o_mem_full=1, o_load_words=128. 4 extra bytes → mem[0] unchanged. Load 3 bytes then drop i_load_en → nothing written.
- Assert i_reset=0 asynchronously mid-cycle during run → PC=0, o_instruction=0, o_halted=0 before the next edge. Memory contents are retained.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - decode/hazard/debug signal bundle of the fetch stage
interface fetch_stage_if #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 7,
   parameter int NB_BYTE = 8
);
   logic               i_enable;
   logic               i_pc_write;
   logic               i_IF_ID_write;
   logic               i_branch_or_jump;
   logic [1:0]         i_pc_src;
   logic [NB_ADDR-1:0] i_addr_branch;
   logic [NB_ADDR-1:0] i_addr_jump;
   logic [NB_ADDR-1:0] i_addr_register;
   logic               i_halt;
   logic               i_load_en;
   logic               i_load_valid;
   logic [NB_BYTE-1:0] i_load_byte;
   logic [NB_DATA-1:0] o_instruction;
   logic [NB_ADDR-1:0] o_pc;
   logic [NB_ADDR-1:0] o_pc_current;
   logic               o_halted;
   logic [NB_ADDR:0]   o_load_words;
   logic               o_mem_full;

   modport slave (
      input  i_enable, i_pc_write, i_IF_ID_write, i_branch_or_jump, i_pc_src,
             i_addr_branch, i_addr_jump, i_addr_register, i_halt,
             i_load_en, i_load_valid, i_load_byte,
      output o_instruction, o_pc, o_pc_current, o_halted, o_load_words, o_mem_full
   );

   modport master (
      output i_enable, i_pc_write, i_IF_ID_write, i_branch_or_jump, i_pc_src,
             i_addr_branch, i_addr_jump, i_addr_register, i_halt,
             i_load_en, i_load_valid, i_load_byte,
      input  o_instruction, o_pc, o_pc_current, o_halted, o_load_words, o_mem_full
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC, instruction memory, IF/ID register, program loader
module fetch_stage #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 7,
   parameter int NB_BYTE = 8
) (
   input  logic         i_clock,
   input  logic         i_reset,
   fetch_stage_if.slave bus
);
   localparam int                 DEPTH     = 1 << NB_ADDR;
   localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DEPTH - 1);

   logic [NB_DATA-1:0]         mem [DEPTH];
   logic [NB_ADDR-1:0]         pc_q, pc_d, ifid_pc_q, ifid_pc_d, load_addr_q, load_addr_d;
   logic [NB_DATA-1:0]         instr_q, instr_d;
   logic                       halted_q, halted_d, mem_full_q, mem_full_d, load_en_q, load_en_d;
   logic [1:0]                 byte_cnt_q, byte_cnt_d;
   logic [NB_DATA-NB_BYTE-1:0] shift_q, shift_d;
   logic [NB_ADDR:0]           load_words_q, load_words_d;
   logic                       mem_we;
   logic [NB_DATA-1:0]         mem_wdata, fetch_word;
   logic [NB_ADDR-1:0]         pc_plus1, target;

   assign fetch_word = mem[pc_q];
   assign pc_plus1   = pc_q + 1'b1;

   always_comb begin
      case (bus.i_pc_src)
         2'b01:   target = bus.i_addr_branch;
         2'b10:   target = bus.i_addr_jump;
         2'b11:   target = bus.i_addr_register;
         default: target = pc_plus1;
      endcase
   end

   always_comb begin
      pc_d         = pc_q;
      instr_d      = instr_q;
      ifid_pc_d    = ifid_pc_q;
      halted_d     = halted_q;
      byte_cnt_d   = byte_cnt_q;
      load_addr_d  = load_addr_q;
      shift_d      = shift_q;
      load_words_d = load_words_q;
      mem_full_d   = mem_full_q;
      load_en_d    = bus.i_load_en;
      mem_we       = 1'b0;
      mem_wdata    = {shift_q, bus.i_load_byte};
      if (bus.i_load_en) begin
         pc_d      = '0;
         instr_d   = '0;
         ifid_pc_d = '0;
         halted_d  = 1'b0;
         // Counters restart on the rising edge of load mode; a stale full flag must not block the first byte.
         if (!load_en_q) begin
            load_words_d = '0;
            mem_full_d   = 1'b0;
         end
         if (bus.i_load_valid && !(mem_full_q && load_en_q)) begin
            if (byte_cnt_q == 2'd3) begin
               mem_we       = 1'b1;
               byte_cnt_d   = 2'd0;
               load_addr_d  = load_addr_q + 1'b1;
               load_words_d = load_words_d + 1'b1;
               if (load_addr_q == LAST_ADDR) mem_full_d = 1'b1;
            end else begin
               shift_d    = {shift_q[NB_DATA-2*NB_BYTE-1:0], bus.i_load_byte};
               byte_cnt_d = byte_cnt_q + 2'd1;
            end
         end
      end else begin
         byte_cnt_d  = 2'd0;
         load_addr_d = '0;
         if (!halted_q && bus.i_enable) begin
            if (bus.i_halt) begin
               halted_d = 1'b1;
            end else begin
               if (bus.i_pc_write) pc_d = bus.i_branch_or_jump ? target : pc_plus1;
               if (bus.i_IF_ID_write) begin
                  if (bus.i_pc_write && bus.i_branch_or_jump) begin
                     instr_d   = '0;
                     ifid_pc_d = target;
                  end else begin
                     instr_d   = fetch_word;
                     ifid_pc_d = pc_plus1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         pc_q         <= '0;
         instr_q      <= '0;
         ifid_pc_q    <= '0;
         halted_q     <= 1'b0;
         byte_cnt_q   <= 2'd0;
         load_addr_q  <= '0;
         shift_q      <= '0;
         load_words_q <= '0;
         mem_full_q   <= 1'b0;
         load_en_q    <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         ifid_pc_q    <= ifid_pc_d;
         halted_q     <= halted_d;
         byte_cnt_q   <= byte_cnt_d;
         load_addr_q  <= load_addr_d;
         shift_q      <= shift_d;
         load_words_q <= load_words_d;
         mem_full_q   <= mem_full_d;
         load_en_q    <= load_en_d;
      end
   end

   // Program memory survives reset so a reset mid-run keeps the loaded image.
   always_ff @(posedge i_clock) begin
      if (mem_we) mem[load_addr_q] <= mem_wdata;
   end

   assign bus.o_instruction = instr_q;
   assign bus.o_pc          = ifid_pc_q;
   assign bus.o_pc_current  = pc_q;
   assign bus.o_halted      = halted_q;
   assign bus.o_load_words  = load_words_q;
   assign bus.o_mem_full    = mem_full_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_stage_if #(.NB_DATA(32), .NB_ADDR(7), .NB_BYTE(8)) bus ();
   fetch_stage #(.NB_DATA(32), .NB_ADDR(7), .NB_BYTE(8)) dut (
      .i_clock(clk), .i_reset(rst_n), .bus(bus)
   );

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  ifpc;
      logic [6:0]  pccur;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        pe, ce;
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model_mem [128];
   logic [6:0]  m_pc, m_ifpc;
   logic [31:0] m_instr;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle;
      bus.i_enable = 1'b0;         bus.i_pc_write = 1'b1;      bus.i_IF_ID_write = 1'b1;
      bus.i_branch_or_jump = 1'b0; bus.i_pc_src = 2'b00;       bus.i_halt = 1'b0;
      bus.i_addr_branch = 7'h10;   bus.i_addr_jump = 7'h20;    bus.i_addr_register = 7'h30;
      bus.i_load_en = 1'b0;        bus.i_load_valid = 1'b0;    bus.i_load_byte = 8'h00;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.i_load_valid = 1'b1;
      bus.i_load_byte  = b;
      tick();
      bus.i_load_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
   endtask

   task automatic push_exp;
      pe.instr = m_instr; pe.ifpc = m_ifpc; pe.pccur = m_pc;
      exp_q.push_back(pe);
   endtask

   task automatic push_seq;
      m_instr = model_mem[m_pc];
      m_ifpc  = m_pc + 7'd1;
      m_pc    = m_pc + 7'd1;
      push_exp();
   endtask

   task automatic test_reset;
      drive_idle();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({bus.o_instruction, bus.o_pc, bus.o_pc_current, bus.o_halted, bus.o_load_words, bus.o_mem_full} !== 56'd0) begin
         failures++;
         $display("FAIL reset_state got=%h/%h/%h/%b/%h/%b exp=all zero", bus.o_instruction, bus.o_pc,
                  bus.o_pc_current, bus.o_halted, bus.o_load_words, bus.o_mem_full);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_load;
      bus.i_load_en = 1'b1;
      tick();
      send_word(32'h20010005);
      send_word(32'h20020003);
      model_mem[0] = 32'h20010005;
      model_mem[1] = 32'h20020003;
      checks++;
      if (bus.o_load_words !== 8'd2 || bus.o_mem_full !== 1'b0) begin
         failures++;
         $display("FAIL load_two_words got=%0d/%b exp=2/0", bus.o_load_words, bus.o_mem_full);
      end
      bus.i_load_en = 1'b0;
      bus.i_enable  = 1'b1;
      m_pc = 7'd0;
      for (int k = 0; k < 2; k++) begin
         push_seq();
         tick();
         ce = exp_q.pop_front();
         checks++;
         if ({bus.o_instruction, bus.o_pc, bus.o_pc_current} !== {ce.instr, ce.ifpc, ce.pccur}) begin
            failures++;
            $display("FAIL load_run got=%h/%h/%h exp=%h/%h/%h", bus.o_instruction, bus.o_pc,
                     bus.o_pc_current, ce.instr, ce.ifpc, ce.pccur);
         end
      end
      bus.i_enable = 1'b0;
      checks++;
      if (bus.o_load_words !== 8'd2) begin
         failures++;
         $display("FAIL load_words_hold got=%0d exp=2", bus.o_load_words);
      end
   endtask

   task automatic test_fill;
      logic [7:0]  ib;
      logic [31:0] w;
      bus.i_load_en = 1'b1;
      tick();
      for (int i = 0; i < 128; i++) begin
         ib = 8'(i);
         w  = {ib, 8'h5A, ~ib, 8'h3C};
         model_mem[i] = w;
         send_word(w);
         if (i == 126) begin
            checks++;
            if (bus.o_mem_full !== 1'b0 || bus.o_load_words !== 8'd127) begin
               failures++;
               $display("FAIL fill_127 got=%b/%0d exp=0/127", bus.o_mem_full, bus.o_load_words);
            end
         end
      end
      checks++;
      if (bus.o_mem_full !== 1'b1 || bus.o_load_words !== 8'd128) begin
         failures++;
         $display("FAIL fill_128 got=%b/%0d exp=1/128", bus.o_mem_full, bus.o_load_words);
      end
      send_word(32'hFFFFFFFF);
      checks++;
      if (bus.o_mem_full !== 1'b1 || bus.o_load_words !== 8'd128) begin
         failures++;
         $display("FAIL fill_extra got=%b/%0d exp=1/128", bus.o_mem_full, bus.o_load_words);
      end
      bus.i_load_en = 1'b0;
      bus.i_enable  = 1'b1;
      m_pc = 7'd0;
      push_seq();
      tick();
      bus.i_enable = 1'b0;
      ce = exp_q.pop_front();
      checks++;
      if ({bus.o_instruction, bus.o_pc, bus.o_pc_current} !== {ce.instr, ce.ifpc, ce.pccur}) begin
         failures++;
         $display("FAIL fill_mem0 got=%h/%h/%h exp=%h/%h/%h", bus.o_instruction, bus.o_pc,
                  bus.o_pc_current, ce.instr, ce.ifpc, ce.pccur);
      end
   endtask

   task automatic test_partial;
      bus.i_load_en = 1'b1;
      tick();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      bus.i_load_en = 1'b0;
      checks++;
      if (bus.o_load_words !== 8'd0 || bus.o_mem_full !== 1'b0) begin
         failures++;
         $display("FAIL partial_counts got=%0d/%b exp=0/0", bus.o_load_words, bus.o_mem_full);
      end
      bus.i_enable = 1'b1;
      m_pc = 7'd0;
      push_seq();
      tick();
      bus.i_enable = 1'b0;
      ce = exp_q.pop_front();
      checks++;
      if ({bus.o_instruction, bus.o_pc, bus.o_pc_current} !== {ce.instr, ce.ifpc, ce.pccur}) begin
         failures++;
         $display("FAIL partial_mem0 got=%h/%h/%h exp=%h/%h/%h", bus.o_instruction, bus.o_pc,
                  bus.o_pc_current, ce.instr, ce.ifpc, ce.pccur);
      end
   endtask

   task automatic test_redirect;
      logic [1:0] srcs [4];
      logic [6:0] tgt;
      srcs[0] = 2'b01; srcs[1] = 2'b10; srcs[2] = 2'b11; srcs[3] = 2'b00;
      bus.i_enable = 1'b1;
      for (int s = -3; s < 8; s++) begin
         if (s < 0) begin
            push_seq();
         end else if (s[0] == 1'b0) begin
            bus.i_branch_or_jump = 1'b1;
            bus.i_pc_src = srcs[s/2];
            case (srcs[s/2])
               2'b01:   tgt = 7'h10;
               2'b10:   tgt = 7'h20;
               2'b11:   tgt = 7'h30;
               default: tgt = m_pc + 7'd1;
            endcase
            m_pc = tgt; m_ifpc = tgt; m_instr = 32'd0;
            push_exp();
         end else begin
            bus.i_branch_or_jump = 1'b0;
            bus.i_pc_src = 2'b00;
            push_seq();
         end
         tick();
         ce = exp_q.pop_front();
         checks++;
         if ({bus.o_instruction, bus.o_pc, bus.o_pc_current} !== {ce.instr, ce.ifpc, ce.pccur}) begin
            failures++;
            $display("FAIL redirect_step%0d got=%h/%h/%h exp=%h/%h/%h", s, bus.o_instruction, bus.o_pc,
                     bus.o_pc_current, ce.instr, ce.ifpc, ce.pccur);
         end
      end
      bus.i_enable = 1'b0;
   endtask

   task automatic test_stall;
      bus.i_enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k < 2) begin
            bus.i_branch_or_jump = 1'b1; bus.i_pc_src = 2'b01;
            bus.i_pc_write = 1'b0;       bus.i_IF_ID_write = 1'b0;
            push_exp();
         end else begin
            bus.i_branch_or_jump = 1'b0; bus.i_pc_src = 2'b00;
            bus.i_pc_write = 1'b1;       bus.i_IF_ID_write = 1'b1;
            push_seq();
         end
         tick();
         ce = exp_q.pop_front();
         checks++;
         if ({bus.o_instruction, bus.o_pc, bus.o_pc_current} !== {ce.instr, ce.ifpc, ce.pccur}) begin
            failures++;
            $display("FAIL stall_step%0d got=%h/%h/%h exp=%h/%h/%h", k, bus.o_instruction, bus.o_pc,
                     bus.o_pc_current, ce.instr, ce.ifpc, ce.pccur);
         end
      end
      bus.i_enable = 1'b0;
   endtask

   task automatic test_halt;
      bus.i_enable = 1'b1;
      for (int k = 0; k < 130 && m_pc != 7'd6; k++) begin
         push_seq();
         tick();
         ce = exp_q.pop_front();
         checks++;
         if ({bus.o_instruction, bus.o_pc, bus.o_pc_current} !== {ce.instr, ce.ifpc, ce.pccur}) begin
            failures++;
            $display("FAIL halt_approach got=%h/%h/%h exp=%h/%h/%h", bus.o_instruction, bus.o_pc,
                     bus.o_pc_current, ce.instr, ce.ifpc, ce.pccur);
         end
      end
      for (int k = 0; k < 5; k++) begin
         bus.i_halt = (k == 0);
         if (k == 4) begin
            bus.i_load_en = 1'b1;
            m_pc = 7'd0; m_ifpc = 7'd0; m_instr = 32'd0;
         end
         push_exp();
         tick();
         bus.i_halt = 1'b0;
         bus.i_load_en = 1'b0;
         ce = exp_q.pop_front();
         checks++;
         if ({bus.o_instruction, bus.o_pc, bus.o_pc_current, bus.o_halted} !== {ce.instr, ce.ifpc, ce.pccur, (k != 4)}) begin
            failures++;
            $display("FAIL halt_step%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", k, bus.o_instruction, bus.o_pc,
                     bus.o_pc_current, bus.o_halted, ce.instr, ce.ifpc, ce.pccur, (k != 4));
         end
      end
      bus.i_enable = 1'b0;
   endtask

   task automatic test_async_reset;
      bus.i_enable = 1'b1;
      push_seq(); push_seq();
      for (int k = 0; k < 2; k++) begin
         tick();
         ce = exp_q.pop_front();
         checks++;
         if ({bus.o_instruction, bus.o_pc, bus.o_pc_current} !== {ce.instr, ce.ifpc, ce.pccur}) begin
            failures++;
            $display("FAIL arst_prerun got=%h/%h/%h exp=%h/%h/%h", bus.o_instruction, bus.o_pc,
                     bus.o_pc_current, ce.instr, ce.ifpc, ce.pccur);
         end
      end
      bus.i_halt = 1'b1;
      tick();
      bus.i_halt = 1'b0;
      checks++;
      if (bus.o_halted !== 1'b1) begin
         failures++;
         $display("FAIL arst_halted_set got=%b exp=1", bus.o_halted);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.o_instruction, bus.o_pc, bus.o_pc_current, bus.o_halted} !== 47'd0) begin
         failures++;
         $display("FAIL arst_immediate got=%h/%h/%h/%b exp=0/0/0/0", bus.o_instruction, bus.o_pc,
                  bus.o_pc_current, bus.o_halted);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_pc = 7'd0;
      push_seq();
      tick();
      bus.i_enable = 1'b0;
      ce = exp_q.pop_front();
      checks++;
      if ({bus.o_instruction, bus.o_pc, bus.o_pc_current} !== {ce.instr, ce.ifpc, ce.pccur}) begin
         failures++;
         $display("FAIL arst_mem_kept got=%h/%h/%h exp=%h/%h/%h", bus.o_instruction, bus.o_pc,
                  bus.o_pc_current, ce.instr, ce.ifpc, ce.pccur);
      end
   endtask

   initial begin
      m_pc = 7'd0; m_ifpc = 7'd0; m_instr = 32'd0;
      test_reset();
      test_load();
      test_fill();
      test_partial();
      test_redirect();
      test_stall();
      test_halt();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
